// File: rtl/fifo_pkg.sv
// Shared sizing helpers for the multi-channel FIFO: depth, count width and channel slicing.
package fifo_pkg;

    function automatic int fifo_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

    // Count must represent 0..DEPTH inclusive, hence one bit more than the pointers.
    function automatic int fifo_cnt_w(input int addr_w);
        return addr_w + 1;
    endfunction

    function automatic int ch_lsb(input int ch, input int width);
        return ch * width;
    endfunction

endpackage

// File: rtl/fifo_ch.sv
// One FIFO channel: full-depth storage, 1-cycle registered read, count-derived flags, error flag.
// Latency: read data one cycle after accept. Backpressure: writes refused at full unless a read frees a slot.
// Optional FIFO_STICKY_ERR_EN: error latches until err_clr or reset.
module fifo_ch
    import fifo_pkg::*;
#(
    parameter int DATA_SIZE = 12,
    parameter int ADDR_W    = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 write,
    input  logic                 read,
    input  logic [DATA_SIZE-1:0] data_in,
    input  logic [ADDR_W:0]      th_almost_full,
    input  logic [ADDR_W:0]      th_almost_empty,
`ifdef FIFO_STICKY_ERR_EN
    input  logic                 err_clr,
`endif
    output logic [DATA_SIZE-1:0] data_out,
    output logic                 valid,
    output logic                 fifo_full,
    output logic                 fifo_empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic                 fifo_error,
    output logic [ADDR_W:0]      count
);

    localparam int DEPTH = fifo_depth(ADDR_W);
    localparam int CNT_W = fifo_cnt_w(ADDR_W);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_SIZE-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DATA_SIZE-1:0] dout_q, dout_d;
    logic                 vld_q, vld_d;
    logic                 err_q, err_d;

    logic empty, full, rd_acc, wr_acc, ovf, unf;

    assign empty  = (cnt_q == '0);
    assign full   = (cnt_q == FULL_CNT);
    assign rd_acc = read & ~empty;
    // A read in the same cycle frees the slot, so a write at full still lands.
    assign wr_acc = write & (~full | rd_acc);
    assign ovf    = write & ~wr_acc;
    assign unf    = read & empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        dout_d   = dout_q;
        vld_d    = 1'b0;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            dout_d   = mem_q[rd_ptr_q];
            vld_d    = 1'b1;
        end
        case ({wr_acc, rd_acc})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
`ifdef FIFO_STICKY_ERR_EN
        // A fresh error takes priority over a clear in the same cycle.
        err_d = ovf | unf | (err_q & ~err_clr);
`else
        err_d = ovf | unf;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            dout_q   <= '0;
            vld_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
            vld_q    <= vld_d;
            err_q    <= err_d;
        end
    end

    // Storage is not reset; stale words are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (!reset && wr_acc) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    assign data_out     = dout_q;
    assign valid        = vld_q;
    assign fifo_full    = full;
    assign fifo_empty   = empty;
    assign almost_full  = (cnt_q >= th_almost_full);
    assign almost_empty = (cnt_q <= th_almost_empty);
    assign fifo_error   = err_q;
    assign count        = cnt_q;

endmodule

// File: rtl/fifo_multi_ch.sv
// NUM_CH independent FIFO channels (one per traffic class) with packed per-channel buses.
// Latency: 1 cycle read-to-data per channel. Backpressure: per-channel full flag; refused writes raise fifo_error.
// Optional FIFO_STICKY_ERR_EN adds err_clr and makes fifo_error sticky.
module fifo_multi_ch
    import fifo_pkg::*;
#(
    parameter int DATA_SIZE = 12,
    parameter int ADDR_W    = 3,
    parameter int NUM_CH    = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_CH-1:0]           write,
    input  logic [NUM_CH-1:0]           read,
    input  logic [NUM_CH*DATA_SIZE-1:0] data_in,
    input  logic [ADDR_W:0]             th_almost_full,
    input  logic [ADDR_W:0]             th_almost_empty,
`ifdef FIFO_STICKY_ERR_EN
    input  logic [NUM_CH-1:0]           err_clr,
`endif
    output logic [NUM_CH*DATA_SIZE-1:0] data_out,
    output logic [NUM_CH-1:0]           valid,
    output logic [NUM_CH-1:0]           fifo_full,
    output logic [NUM_CH-1:0]           fifo_empty,
    output logic [NUM_CH-1:0]           almost_full,
    output logic [NUM_CH-1:0]           almost_empty,
    output logic [NUM_CH-1:0]           fifo_error,
    output logic [NUM_CH*(ADDR_W+1)-1:0] count
);

    localparam int CNT_W = fifo_cnt_w(ADDR_W);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        fifo_ch #(
            .DATA_SIZE (DATA_SIZE),
            .ADDR_W    (ADDR_W)
        ) u_ch (
            .clk             (clk),
            .reset           (reset),
            .write           (write[c]),
            .read            (read[c]),
            .data_in         (data_in[ch_lsb(c, DATA_SIZE) +: DATA_SIZE]),
            .th_almost_full  (th_almost_full),
            .th_almost_empty (th_almost_empty),
`ifdef FIFO_STICKY_ERR_EN
            .err_clr         (err_clr[c]),
`endif
            .data_out        (data_out[ch_lsb(c, DATA_SIZE) +: DATA_SIZE]),
            .valid           (valid[c]),
            .fifo_full       (fifo_full[c]),
            .fifo_empty      (fifo_empty[c]),
            .almost_full     (almost_full[c]),
            .almost_empty    (almost_empty[c]),
            .fifo_error      (fifo_error[c]),
            .count           (count[ch_lsb(c, CNT_W) +: CNT_W])
        );
    end

endmodule
